// File: rtl/fifo_burst_reader_if.sv
// Bus bundle between the burst reader, its upstream synchronous FIFO and the
// downstream beat consumer. The reader uses the master modport; the FIFO and
// the consumer (or a bench) use the slave modport.
interface fifo_burst_reader_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 128
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_rd_data;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_data_cnt;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;

   modport master (
      output fifo_rd_en, m_valid, m_data, m_last,
      input  fifo_rd_data, fifo_empty, fifo_data_cnt, m_ready
   );

   modport slave (
      input  fifo_rd_en, m_valid, m_data, m_last,
      output fifo_rd_data, fifo_empty, fifo_data_cnt, m_ready
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst reader: waits until the upstream FIFO holds a full burst (or a partial
// burst has sat idle for TIMEOUT cycles), then pops exactly blen entries and
// streams them out through a 2-entry skid buffer with m_last on the final beat.
module fifo_burst_reader #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 128,
   parameter int BURST_LEN = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   fifo_burst_reader_if.master        bus,
   output logic                       busy
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = $clog2(BURST_LEN) + 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [CW-1:0] FULL_CNT  = CW'(BURST_LEN);
   localparam logic [BW-1:0] FULL_BLEN = BW'(BURST_LEN);
   localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state, state_nxt;
   logic [TW-1:0]     idle_cnt;
   logic [BW-1:0]     blen;
   logic [BW-1:0]     issued;
   logic [BW-1:0]     delivered;

   // Pop issued last cycle: its data lands on fifo_rd_data this cycle.
   logic              rd_vld_p1;
   logic              rd_last_p1;

   logic [WIDTH-1:0]  sb_data [2];
   logic              sb_last [2];
   logic              sb_wr_ptr;
   logic              sb_rd_ptr;
   logic [1:0]        sb_cnt;

   logic              rd_en;
   logic              out_vld;
   logic              out_last;
   logic              accept;
   logic              full_go;
   logic              part_go;
   logic              start;
   logic [1:0]        occ;

   assign out_vld  = (sb_cnt != 2'd0);
   assign out_last = out_vld && sb_last[sb_rd_ptr];
   assign accept   = out_vld && bus.m_ready;

   assign full_go  = (bus.fifo_data_cnt >= FULL_CNT);
   assign part_go  = (TIMEOUT != 0) && (bus.fifo_data_cnt != '0) && (idle_cnt == TO_LIM);

   // Slots that will be taken once the beat leaving this cycle is gone; the
   // departing beat frees its slot so a pop can be issued every cycle.
   assign occ = sb_cnt - {1'b0, accept} + {1'b0, rd_vld_p1};

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = out_vld;
   assign bus.m_data     = sb_data[sb_rd_ptr];
   assign bus.m_last     = out_last;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode, pop request and busy flag.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      busy      = 1'b0;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (full_go || part_go) begin
               state_nxt = BURST;
               start     = 1'b1;
            end
         end
         BURST: begin
            busy  = 1'b1;
            rd_en = (issued < blen) && !bus.fifo_empty && (occ < 2'd2);
            if (accept && out_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Burst length latch, issue/deliver counters and the idle timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt  <= '0;
         blen      <= '0;
         issued    <= '0;
         delivered <= '0;
      end else if (start) begin
         blen      <= full_go ? FULL_BLEN : BW'(bus.fifo_data_cnt);
         issued    <= '0;
         delivered <= '0;
         idle_cnt  <= '0;
      end else begin
         if (rd_en)  issued    <= issued + BW'(1);
         if (accept) delivered <= delivered + BW'(1);
         if (state == IDLE) begin
            if (bus.fifo_data_cnt == '0)
               idle_cnt <= '0;
            else if ((bus.fifo_data_cnt < FULL_CNT) && (idle_cnt != TO_LIM))
               idle_cnt <= idle_cnt + TW'(1);
         end
      end
   end

   // Read-latency stage: remember that a pop is in flight and whether it is the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_p1  <= 1'b0;
         rd_last_p1 <= 1'b0;
      end else begin
         rd_vld_p1  <= rd_en;
         rd_last_p1 <= rd_en && ((issued + BW'(1)) == blen);
      end
   end

   // Two-entry skid buffer holding returned beats until the consumer takes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_data[0] <= '0;
         sb_data[1] <= '0;
         sb_last[0] <= 1'b0;
         sb_last[1] <= 1'b0;
         sb_wr_ptr  <= 1'b0;
         sb_rd_ptr  <= 1'b0;
         sb_cnt     <= 2'd0;
      end else begin
         if (rd_vld_p1) begin
            sb_data[sb_wr_ptr] <= bus.fifo_rd_data;
            sb_last[sb_wr_ptr] <= rd_last_p1;
            sb_wr_ptr          <= ~sb_wr_ptr;
         end
         if (accept) sb_rd_ptr <= ~sb_rd_ptr;
         sb_cnt <= sb_cnt + {1'b0, rd_vld_p1} - {1'b0, accept};
      end
   end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-based FIFO model feeds the main
// instance; two small instances cover TIMEOUT=0 and BURST_LEN=1.
module tb_fifo_burst_reader;
   logic clk = 1'b0;
   logic rst_n;
   logic busy_a, busy_b, busy_c;

   always #5 clk = ~clk;

   fifo_burst_reader_if #(.WIDTH(8), .DEPTH(128)) bus_a ();
   fifo_burst_reader_if #(.WIDTH(8), .DEPTH(16))  bus_b ();
   fifo_burst_reader_if #(.WIDTH(8), .DEPTH(16))  bus_c ();

   fifo_burst_reader #(.WIDTH(8), .DEPTH(128), .BURST_LEN(16), .TIMEOUT(64)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .busy(busy_a));
   fifo_burst_reader #(.WIDTH(8), .DEPTH(16), .BURST_LEN(4), .TIMEOUT(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .busy(busy_b));
   fifo_burst_reader #(.WIDTH(8), .DEPTH(16), .BURST_LEN(1), .TIMEOUT(64)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c), .busy(busy_c));

   int compared = 0;
   int failed   = 0;
   int cyc      = 0;
   int pops     = 0;
   int acc      = 0;
   int max_out  = 0;
   logic [7:0] nv = 8'h10;
   logic [7:0] q[$];
   logic [7:0] got_d[$];
   logic       got_l[$];
   int         got_c[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: data valid one cycle after an accepted pop.
   always @(posedge clk) begin
      if (bus_a.fifo_rd_en) begin
         compared++;
         assert (q.size() > 0) else begin
            failed++;
            $error("FAIL pop_on_empty: observed pop with size %0d, expected size > 0", q.size());
         end
         if (q.size() > 0) bus_a.fifo_rd_data <= q.pop_front();
         pops <= pops + 1;
      end
      bus_a.fifo_data_cnt <= 8'(q.size());
      bus_a.fifo_empty    <= (q.size() == 0);
   end

   // Beat monitor: records the handshake that completes at the next rising edge.
   always @(negedge clk) begin
      if (pops - acc > max_out) max_out = pops - acc;
      if (rst_n && bus_a.m_valid && bus_a.m_ready) begin
         got_d.push_back(bus_a.m_data);
         got_l.push_back(bus_a.m_last);
         got_c.push_back(cyc);
         acc++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         q.push_back(nv);
         nv = nv + 8'd1;
      end
   endtask

   task automatic clear_log();
      got_d.delete();
      got_l.delete();
      got_c.delete();
   endtask

   task automatic run_burst(input int n, input bit toggle, input int budget);
      for (int k = 0; k < budget; k++) begin
         step(1);
         if (toggle) bus_a.m_ready = ~bus_a.m_ready;
         if (got_d.size() >= n && !busy_a) break;
      end
      bus_a.m_ready = 1'b1;
   endtask

   task automatic check_beats(input string tag, input int n, input logic [7:0] first);
      logic [8:0] e;
      chk({tag, "_count"}, 32'(got_d.size()), 32'(n));
      for (int i = 0; i < n && i < got_d.size(); i++) begin
         e = {(i == n - 1), 8'(first + 8'(i))};
         chk($sformatf("%s_beat%0d", tag, i + 1), 32'({got_l[i], got_d[i]}), 32'(e));
      end
   endtask

   initial begin
      int p0;
      bit bad, bad_v, bad_s, bad_r;
      logic [7:0] d0, head;
      logic       l0;

      rst_n = 1'b0;
      bus_a.m_ready = 1'b0;
      bus_b.m_ready = 1'b1;  bus_b.fifo_rd_data = 8'h5A; bus_b.fifo_empty = 1'b0; bus_b.fifo_data_cnt = 5'd0;
      bus_c.m_ready = 1'b1;  bus_c.fifo_rd_data = 8'hA5; bus_c.fifo_empty = 1'b1; bus_c.fifo_data_cnt = 5'd0;
      step(3);
      chk("rst_busy",    32'(busy_a), 32'd0);
      chk("rst_rd_en",   32'(bus_a.fifo_rd_en), 32'd0);
      chk("rst_m_valid", 32'(bus_a.m_valid), 32'd0);
      chk("rst_m_data",  32'(bus_a.m_data), 32'd0);
      chk("rst_m_last",  32'(bus_a.m_last), 32'd0);
      rst_n = 1'b1;

      // Full burst from 20 preloaded entries, consumer always ready.
      clear_log();
      bus_a.m_ready = 1'b1;
      p0 = pops;
      push(20);
      run_burst(16, 1'b0, 200);
      check_beats("full", 16, 8'h10);
      chk("full_consecutive", 32'(got_c[15] - got_c[0]), 32'd15);
      chk("full_busy_after", 32'(busy_a), 32'd0);
      chk("full_pops", 32'(pops - p0), 32'd16);
      chk("full_cnt_left", 32'(bus_a.fifo_data_cnt), 32'd4);

      // Partial burst of 5 after the idle timeout.
      clear_log();
      push(1);
      p0 = pops;
      bad = 1'b0;
      repeat (64) begin
         step(1);
         if (bus_a.fifo_rd_en || busy_a) bad = 1'b1;
      end
      chk("timeout_no_early_pop", 32'(bad), 32'd0);
      run_burst(5, 1'b0, 100);
      check_beats("partial", 5, 8'h20);
      chk("partial_pops", 32'(pops - p0), 32'd5);

      // Full burst with the consumer toggling ready every cycle.
      clear_log();
      max_out = 0;
      push(16);
      run_burst(16, 1'b1, 300);
      check_beats("toggle", 16, 8'h25);
      chk("toggle_outstanding_le2", 32'(max_out <= 2), 32'd1);

      // Consumer stalls for 10 cycles after three beats.
      clear_log();
      push(16);
      for (int k = 0; k < 50 && got_d.size() < 3; k++) step(1);
      bus_a.m_ready = 1'b0;
      d0 = bus_a.m_data;
      l0 = bus_a.m_last;
      chk("stall_head", 32'(d0), 32'h38);
      bad_v = 1'b0; bad_s = 1'b0; bad_r = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (!bus_a.m_valid) bad_v = 1'b1;
         if (bus_a.m_data !== d0 || bus_a.m_last !== l0) bad_s = 1'b1;
         if (k >= 1 && bus_a.fifo_rd_en) bad_r = 1'b1;
      end
      chk("stall_valid_held", 32'(bad_v), 32'd0);
      chk("stall_data_stable", 32'(bad_s), 32'd0);
      chk("stall_no_pop", 32'(bad_r), 32'd0);
      bus_a.m_ready = 1'b1;
      run_burst(16, 1'b0, 200);
      check_beats("stall", 16, 8'h35);

      // Reset pulsed while beat 7 is on the output.
      clear_log();
      push(16);
      for (int k = 0; k < 50 && got_d.size() < 6; k++) step(1);
      chk("mid_beat7_valid", 32'(bus_a.m_valid), 32'd1);
      chk("mid_beat7_data", 32'(bus_a.m_data), 32'h4B);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",    32'(busy_a), 32'd0);
      chk("mid_rst_rd_en",   32'(bus_a.fifo_rd_en), 32'd0);
      chk("mid_rst_m_valid", 32'(bus_a.m_valid), 32'd0);
      chk("mid_rst_m_data",  32'(bus_a.m_data), 32'd0);
      chk("mid_rst_m_last",  32'(bus_a.m_last), 32'd0);
      head = q[0];
      push(16 - q.size());
      step(1);
      rst_n = 1'b1;
      clear_log();
      chk("mid_rst_idle", 32'(busy_a), 32'd0);
      run_burst(16, 1'b0, 200);
      check_beats("post_rst", 16, head);

      // TIMEOUT=0: three entries never start a burst; four do.
      bus_b.fifo_data_cnt = 5'd3;
      bad = 1'b0;
      repeat (100) begin
         step(1);
         if (bus_b.fifo_rd_en || busy_b) bad = 1'b1;
      end
      chk("to0_no_burst", 32'(bad), 32'd0);
      bus_b.fifo_data_cnt = 5'd4;
      for (int k = 0; k < 5 && !busy_b; k++) step(1);
      chk("to0_full_burst", 32'(busy_b), 32'd1);

      // BURST_LEN=1: a single beat flagged last.
      bus_c.fifo_data_cnt = 5'd1;
      bus_c.fifo_empty = 1'b0;
      for (int k = 0; k < 10 && !bus_c.m_valid; k++) step(1);
      chk("len1_valid", 32'(bus_c.m_valid), 32'd1);
      chk("len1_last", 32'(bus_c.m_last), 32'd1);
      chk("len1_data", 32'(bus_c.m_data), 32'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width; it SHALL match the upstream synchronous FIFO.
REQ-002 The block SHALL have parameter DEPTH, default 128, meaning the upstream FIFO depth; it sets the fifo_data_cnt width to $clog2(DEPTH)+1.
REQ-003 The block SHALL have parameter BURST_LEN, default 16, meaning the full burst size in beats; legal range is 1..DEPTH.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, meaning the number of idle cycles before a partial burst is flushed; 0 disables partial flush.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port fifo_rd_en, output, 1 bit: the pop request to the upstream FIFO.
REQ-008 The block SHALL have port fifo_rd_data, input, WIDTH bits: FIFO read data, valid exactly 1 cycle after an accepted pop.
REQ-009 The block SHALL have port fifo_empty, input, 1 bit: the upstream FIFO empty flag.
REQ-010 The block SHALL have port fifo_data_cnt, input, $clog2(DEPTH)+1 bits: the upstream FIFO occupancy.
REQ-011 The block SHALL have port m_valid, output, 1 bit: downstream beat valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-013 The block SHALL have port m_data, output, WIDTH bits: downstream beat data.
REQ-014 The block SHALL have port m_last, output, 1 bit: marks the final beat of the burst.
REQ-015 The block SHALL have port busy, output, 1 bit: high while the FSM is in BURST.

Function
REQ-016 The FSM SHALL have two states, IDLE and BURST, and SHALL reset to IDLE.
REQ-017 In IDLE, the FSM SHALL go to BURST when fifo_data_cnt >= BURST_LEN, latching blen = BURST_LEN.
REQ-018 In IDLE, the FSM SHALL go to BURST when TIMEOUT != 0, fifo_data_cnt > 0 and the idle counter equals TIMEOUT, latching blen = fifo_data_cnt.
REQ-019 When the REQ-017 and REQ-018 conditions are both true, the REQ-017 condition SHALL take priority (full burst).
REQ-020 The idle counter SHALL increment, saturating at TIMEOUT, each IDLE cycle with 0 < fifo_data_cnt < BURST_LEN.
REQ-021 The idle counter SHALL clear when fifo_data_cnt == 0 or on entry to BURST.
REQ-022 In BURST, fifo_rd_en SHALL be asserted (combinationally from registered state) only when issued < blen AND !fifo_empty AND (output buffer occupancy + reads in flight) < 2.
REQ-023 fifo_rd_en SHALL never be asserted in IDLE.
REQ-024 Returned data SHALL be written into a 2-entry output skid buffer one cycle after each pop, so no beat is lost when m_ready is low.
REQ-025 m_valid SHALL be high whenever the skid buffer is non-empty; m_data/m_last SHALL stay stable while m_valid && !m_ready.
REQ-026 m_last SHALL be 1 exactly on beat number blen (1-based) of the burst.
REQ-027 The FSM SHALL return from BURST to IDLE in the cycle after m_valid && m_ready && m_last, and busy SHALL drop in that same cycle.
REQ-028 The issued and delivered counters SHALL be $clog2(BURST_LEN)+1 bits wide and SHALL clear on entry to BURST.
REQ-029 Throughput: with m_ready held high and the FIFO holding >= blen entries, the block SHALL deliver one beat per cycle after a 2-cycle start-up (state entry, then FIFO read latency).
REQ-030 A burst of BURST_LEN = 1 SHALL be a single beat with m_last = 1.
REQ-031 A burst of blen beats SHALL cause exactly blen pops; fifo_rd_en SHALL never be asserted while fifo_empty is high.

Reset
REQ-032 Asserting rst_n low at any time, including mid-burst, SHALL immediately force state = IDLE, fifo_rd_en = 0, m_valid = 0, m_data = 0, m_last = 0, busy = 0, and clear all counters and skid-buffer contents.
REQ-033 After rst_n deasserts, the first decision SHALL be made on the first rising edge.
REQ-034 Any data already popped but not delivered when reset asserts SHALL be discarded.

Verification
REQ-035 The bench SHALL cover: BURST_LEN=16, FIFO preloaded with 20 entries, m_ready=1 -> 16 beats on consecutive cycles in FIFO order, m_last on beat 16, busy low afterwards, fifo_data_cnt=4.
REQ-036 The bench SHALL cover: 5 entries, no further writes, TIMEOUT=64 -> no pop for 64 idle cycles, then a 5-beat burst with m_last on beat 5.
REQ-037 The bench SHALL cover: a full burst with m_ready toggling 1/0 every cycle -> all 16 beats delivered in order, none duplicated or dropped, at most 2 pops outstanding beyond accepted beats.
REQ-038 The bench SHALL cover: m_ready held 0 for 10 cycles mid-burst -> m_valid high, m_data/m_last stable, fifo_rd_en low after the skid buffer fills.
REQ-039 The bench SHALL cover: rst_n pulsed low at beat 7 of 16 -> all outputs 0 in the same cycle, IDLE after release, the next burst starts from the current FIFO head.
REQ-040 The bench SHALL cover: TIMEOUT=0 with 3 entries -> no burst is ever issued until fifo_data_cnt reaches BURST_LEN.
